decode_issue_stage: RTL and testbench
=====================================

Name: decode_issue_stage

Overview:
- Registered, parametrised successor to the combinational instruction decoder.
- Sits between fetch and execute in the CPU pipeline.
- Decodes one instruction per cycle through a valid/ready handshake and holds it in one output register.
- Tracks pending register writes in a scoreboard, blocks issue on read-after-write hazards, supports pipeline flush on taken branch/jump, and counts stall cycles.

Parameters:
- INSTR_W, 32, instruction width; opcode occupies the top OPC_W bits.
- OPC_W, 4, opcode field width.
- REG_AW, 5, register address width (fields rd, rs1, rs2 packed below opcode in that order).
- IMM_W, 18, immediate field width (low IMM_W bits of the instruction).
- DATA_W, 32, width of the sign-extended immediate.
- CNT_W, 16, stall counter width.
- Legal only if OPC_W+3*REG_AW <= INSTR_W and OPC_W+2*REG_AW+IMM_W <= INSTR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  INSTR_W  instruction word.
- out_valid  out  1  decoded instruction issuable.
- out_ready  in  1  execute accepts.
- out_alu_op  out  3  ALU operation code.
- out_rd / out_rs1 / out_rs2  out  REG_AW each  register fields.
- out_imm  out  DATA_W  sign-extended immediate.
- out_use_imm  out  1  immediate replaces rs2 operand.
- out_is_beq / out_is_jump  out  1 each  control-flow flags.
- out_illegal  out  1  unknown opcode.
- flush  in  1  discard held instruction.
- wb_valid  in  1  register write completing.
- wb_addr  in  REG_AW  register being written.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Decode table (opcode -> alu_op):
  - 0000/0001 NOOP -> 000.
  - 0010 ADD -> 010.
  - 0011 SUB -> 011.
  - 0100 SHL -> 100.
  - 0101 SHR -> 101.
  - 1100 ADDI -> 110, use_imm=1.
  - 1111 SUBI -> 111, use_imm=1.
  - 1000 JUMP -> 000, is_jump=1.
  - 1001 BEQ -> 000, is_beq=1.
  - Any other opcode -> 000 with illegal=1; the instruction still issues like a NOOP.
- Register use:
  - Writes rd: ADD, SUB, SHL, SHR, ADDI, SUBI.
  - Reads rs1: those six plus BEQ.
  - Reads rs2: ADD, SUB, SHL, SHR, BEQ.
  - JUMP/NOOP/illegal read and write nothing.
  - Register 0 is never busy and never checked.
- Imm: low IMM_W bits, sign-extended from bit IMM_W-1 to DATA_W.
- Latency: decode is registered; out_valid can rise the cycle after the in handshake. Throughput is 1/cycle.
- hazard = hold_valid and (busy[rs1] for a read of rs1, or busy[rs2] for a read of rs2).
- out_valid = hold_valid & !hazard & !flush.
- fire = out_valid & out_ready.
- in_ready = !flush & (!hold_valid | fire). This is a combinational path from out_ready and is permitted.
- Accept when in_valid & in_ready: the hold register loads the decoded fields.
- On fire without a new accept, hold_valid clears.
- All out_* fields are stable while hold_valid & !fire.
- Scoreboard (2^REG_AW busy bits):
  - On fire of a writing instruction with rd!=0, busy[rd] is set.
  - On wb_valid, busy[wb_addr] is cleared.
  - Set and clear of the same register in one cycle: set wins.
  - There is no bypass: a wb clearing a source bit unblocks issue the following cycle.
- flush:
  - hold_valid clears next cycle; no fire occurs this cycle and in_ready=0.
  - The scoreboard is untouched, so in-flight writes still retire.
- stall_cnt increments each cycle in which hold_valid & hazard & !flush, and saturates at all-ones.
- Reset:
  - hold_valid=0, all busy=0, stall_cnt=0.
  - Output fields are 0 (alu_op=000, flags 0), so out_valid=0 and in_ready=1 the cycle after reset.
  - Reset mid-operation discards the held instruction and all pending busy state.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants: OP_NOOP0, OP_NOOP1, OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_ADDI, OP_SUBI, OP_JUMP, OP_BEQ;
  - ALU_* codes;
  - the decoded-instruction struct type.
- One sub-module: reg_scoreboard, holding the busy bits with set/clear/query ports.
- The decode function stays combinational inside the stage.

Test Plan:
- Reset, then in_instr=0x21844000 (ADD r3,r1,r2) with out_ready=1 -> next cycle out_valid=1, alu_op=010, rd=3, rs1=1, rs2=2, use_imm=0; busy[3] set after fire.
- Next instruction 0xC28FFFFF (ADDI r5,r3,-1) -> out_valid=0 and stall_cnt increments each cycle until wb_valid with wb_addr=3. One cycle after wb, out_valid=1, imm=0xFFFFFFFF, alu_op=110.
- Hold out_ready=0 for 3 cycles with an instruction held -> in_ready=0 and outputs stable. Raising out_ready with in_valid gives back-to-back fires, one per cycle.
- Opcode 0110 -> out_illegal=1, alu_op=000, issues, no busy bit set. JUMP 0x8xxxxxxx -> is_jump=1. BEQ r3,r0 issued while busy[3] -> stalls.
- flush asserted while a stalled instruction is held -> out_valid=0 that cycle, hold empty next cycle, busy bits unchanged, stall_cnt stops.
- Same-cycle fire of ADD writing r4 and wb_valid with wb_addr=4 -> busy[4]=1 afterwards. Also force 2^CNT_W stall cycles (CNT_W=4 build) -> stall_cnt holds 0xF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, ALU operation codes and the
// decoded-control struct carried by the decode/issue stage hold register.
package cpu_pkg;

  localparam logic [3:0] OP_NOOP0 = 4'b0000;
  localparam logic [3:0] OP_NOOP1 = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_SHL   = 4'b0100;
  localparam logic [3:0] OP_SHR   = 4'b0101;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1111;
  localparam logic [3:0] OP_JUMP  = 4'b1000;
  localparam logic [3:0] OP_BEQ   = 4'b1001;

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SHL  = 3'b100;
  localparam logic [2:0] ALU_SHR  = 3'b101;
  localparam logic [2:0] ALU_ADDI = 3'b110;
  localparam logic [2:0] ALU_SUBI = 3'b111;

  // Control part of a decoded instruction. wr_rd / rd_rs1 / rd_rs2 drive the
  // scoreboard set and the hazard check; they are not exported as ports.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       use_imm;
    logic       is_beq;
    logic       is_jump;
    logic       illegal;
    logic       wr_rd;
    logic       rd_rs1;
    logic       rd_rs2;
  } dec_ctrl_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all bits)
//   set_en, set_addr    mark a register as having a pending write
//   clr_en, clr_addr    write-back completed, register no longer busy
//   rs1_addr/rs2_addr   query addresses
//   rs1_busy/rs2_busy   registered busy state of the queried registers
// Register 0 is never marked busy. A set and clear of the same register in
// one cycle leaves it busy (the new writer is still in flight).
module reg_scoreboard import cpu_pkg::*; #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  localparam int REG_N = 1 << REG_AW;

  logic [REG_N-1:0] busy_q;
  logic [REG_N-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    // Applied after the clear so a same-cycle set wins.
    if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue pipeline stage between fetch and execute.
// Decodes one instruction per cycle (valid/ready in, valid/ready out) into a
// single hold register, blocks issue on read-after-write hazards using a
// register scoreboard, supports flush, and counts hazard-stall cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_instr   fetch-side handshake and instruction word
//   out_valid/out_ready      execute-side handshake
//   out_alu_op, out_rd, out_rs1, out_rs2, out_imm, out_use_imm,
//   out_is_beq, out_is_jump, out_illegal   decoded instruction fields
//   flush                    discard the held instruction
//   wb_valid/wb_addr         register write-back completing
//   stall_cnt                saturating count of hazard-stall cycles
// Instruction layout: opcode in the top OPC_W bits, then rd, rs1, rs2;
// the immediate is the low IMM_W bits (overlapping rs2).
// Legal parameters need OPC_W+3*REG_AW <= INSTR_W and
// OPC_W+2*REG_AW+IMM_W <= INSTR_W.
module decode_issue_stage import cpu_pkg::*; #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 4,
  parameter int REG_AW  = 5,
  parameter int IMM_W   = 18,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_alu_op,
  output logic [REG_AW-1:0]  out_rd,
  output logic [REG_AW-1:0]  out_rs1,
  output logic [REG_AW-1:0]  out_rs2,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_use_imm,
  output logic               out_is_beq,
  output logic               out_is_jump,
  output logic               out_illegal,
  input  logic               flush,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_addr,
  output logic [CNT_W-1:0]   stall_cnt
);

  // ---------------- combinational decode of the incoming word ----------------
  logic [OPC_W-1:0]         opc;
  logic [REG_AW-1:0]        dec_rd;
  logic [REG_AW-1:0]        dec_rs1;
  logic [REG_AW-1:0]        dec_rs2;
  logic signed [IMM_W-1:0]  dec_imm_raw;
  logic [DATA_W-1:0]        dec_imm;
  dec_ctrl_t                dec_ctrl;

  assign opc         = in_instr[INSTR_W-1 -: OPC_W];
  assign dec_rd      = in_instr[INSTR_W-OPC_W-1 -: REG_AW];
  assign dec_rs1     = in_instr[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
  assign dec_rs2     = in_instr[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];
  assign dec_imm_raw = in_instr[IMM_W-1:0];
  // Size cast of a signed operand sign-extends to DATA_W.
  assign dec_imm     = DATA_W'(dec_imm_raw);

  always_comb begin
    dec_ctrl = '0;
    case (opc)
      OPC_W'(OP_NOOP0),
      OPC_W'(OP_NOOP1): dec_ctrl.alu_op = ALU_NOP;
      OPC_W'(OP_ADD): begin
        dec_ctrl.alu_op = ALU_ADD;
        dec_ctrl.wr_rd  = 1'b1;
        dec_ctrl.rd_rs1 = 1'b1;
        dec_ctrl.rd_rs2 = 1'b1;
      end
      OPC_W'(OP_SUB): begin
        dec_ctrl.alu_op = ALU_SUB;
        dec_ctrl.wr_rd  = 1'b1;
        dec_ctrl.rd_rs1 = 1'b1;
        dec_ctrl.rd_rs2 = 1'b1;
      end
      OPC_W'(OP_SHL): begin
        dec_ctrl.alu_op = ALU_SHL;
        dec_ctrl.wr_rd  = 1'b1;
        dec_ctrl.rd_rs1 = 1'b1;
        dec_ctrl.rd_rs2 = 1'b1;
      end
      OPC_W'(OP_SHR): begin
        dec_ctrl.alu_op = ALU_SHR;
        dec_ctrl.wr_rd  = 1'b1;
        dec_ctrl.rd_rs1 = 1'b1;
        dec_ctrl.rd_rs2 = 1'b1;
      end
      OPC_W'(OP_ADDI): begin
        dec_ctrl.alu_op  = ALU_ADDI;
        dec_ctrl.use_imm = 1'b1;
        dec_ctrl.wr_rd   = 1'b1;
        dec_ctrl.rd_rs1  = 1'b1;
      end
      OPC_W'(OP_SUBI): begin
        dec_ctrl.alu_op  = ALU_SUBI;
        dec_ctrl.use_imm = 1'b1;
        dec_ctrl.wr_rd   = 1'b1;
        dec_ctrl.rd_rs1  = 1'b1;
      end
      OPC_W'(OP_JUMP): dec_ctrl.is_jump = 1'b1;
      OPC_W'(OP_BEQ): begin
        dec_ctrl.is_beq = 1'b1;
        dec_ctrl.rd_rs1 = 1'b1;
        dec_ctrl.rd_rs2 = 1'b1;
      end
      // Unknown opcodes issue as a NOOP with the illegal flag raised.
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  // ---------------- hold register ----------------
  logic              hold_valid_q, hold_valid_d;
  dec_ctrl_t         ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic rs1_busy, rs2_busy;
  logic hazard, fire, accept, sb_set;

  assign hazard    = hold_valid_q & ((ctrl_q.rd_rs1 & rs1_busy) | (ctrl_q.rd_rs2 & rs2_busy));
  assign out_valid = hold_valid_q & ~hazard & ~flush;
  assign fire      = out_valid & out_ready;
  assign in_ready  = ~flush & (~hold_valid_q | fire);
  assign accept    = in_valid & in_ready;
  assign sb_set    = fire & ctrl_q.wr_rd;

  always_comb begin
    hold_valid_d = hold_valid_q;
    ctrl_d       = ctrl_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    imm_d        = imm_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      ctrl_d       = dec_ctrl;
      rd_d         = dec_rd;
      rs1_d        = dec_rs1;
      rs2_d        = dec_rs2;
      imm_d        = dec_imm;
    end else if (fire | flush) begin
      // Fields are left as-is; only the valid bit drops.
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold_valid_q & hazard & ~flush & ~(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      ctrl_q       <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      stall_cnt_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      ctrl_q       <= ctrl_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      imm_q        <= imm_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  reg_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (rd_q),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .rs1_addr (rs1_q),
    .rs2_addr (rs2_q),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  assign out_alu_op  = ctrl_q.alu_op;
  assign out_use_imm = ctrl_q.use_imm;
  assign out_is_beq  = ctrl_q.is_beq;
  assign out_is_jump = ctrl_q.is_jump;
  assign out_illegal = ctrl_q.illegal;
  assign out_rd      = rd_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_imm     = imm_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
module tb_decode_issue_stage;

  localparam int CNT_W     = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_alu_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic        out_use_imm, out_is_beq, out_is_jump, out_illegal;
  logic        flush = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [CNT_W-1:0] stall_cnt;

  decode_issue_stage #(
    .INSTR_W(32), .OPC_W(4), .REG_AW(5), .IMM_W(18), .DATA_W(32), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_is_beq(out_is_beq),
    .out_is_jump(out_is_jump), .out_illegal(out_illegal),
    .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int alu;
    bit use_imm, beq, jump, illegal, wr, r1, r2;
  } info_t;

  function automatic info_t info_of(input logic [31:0] ins);
    info_t i;
    int op;
    op = int'(ins[31:28]);
    i = '{alu: 0, use_imm: 0, beq: 0, jump: 0, illegal: 0, wr: 0, r1: 0, r2: 0};
    if (op == 0 || op == 1) begin
    end else if (op >= 2 && op <= 5) begin   // ADD SUB SHL SHR: alu code equals opcode
      i.alu = op; i.wr = 1; i.r1 = 1; i.r2 = 1;
    end else if (op == 12) begin
      i.alu = 6; i.use_imm = 1; i.wr = 1; i.r1 = 1;
    end else if (op == 15) begin
      i.alu = 7; i.use_imm = 1; i.wr = 1; i.r1 = 1;
    end else if (op == 8) begin
      i.jump = 1;
    end else if (op == 9) begin
      i.beq = 1; i.r1 = 1; i.r2 = 1;
    end else begin
      i.illegal = 1;
    end
    return i;
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    int v;
    v = int'(ins[17:0]);
    if (v >= 131072) v = v - 262144;
    return 32'(v);
  endfunction

  bit          m_known = 0;
  bit          m_hv = 0;
  logic [31:0] m_ins = '0;
  logic [31:0] m_busy = '0;
  int          m_stall = 0;

  // DUT outputs sampled at the falling edge of the last cycle
  logic s_ov, s_ir, s_use_imm, s_beq, s_jump, s_illegal;
  logic [2:0] s_alu;
  logic [4:0] s_rd;
  logic [31:0] s_imm;
  logic [CNT_W-1:0] s_stall;

  task automatic cycle(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl,
                       input bit wbv, input logic [4:0] wba, input bit rs);
    info_t inf;
    bit haz, ov, fire, ir, acc;
    logic [4:0] rd, r1, r2;
    in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
    wb_valid = wbv; wb_addr = wba; rst = rs;
    @(negedge clk);
    inf = info_of(m_ins);
    rd = m_ins[27:23]; r1 = m_ins[22:18]; r2 = m_ins[17:13];
    haz  = m_hv && ((inf.r1 && r1 != 0 && m_busy[r1]) || (inf.r2 && r2 != 0 && m_busy[r2]));
    ov   = m_hv && !haz && !fl;
    fire = ov && ordy;
    ir   = !fl && (!m_hv || fire);
    acc  = iv && ir;
    s_ov = out_valid; s_ir = in_ready; s_alu = out_alu_op; s_rd = out_rd; s_imm = out_imm;
    s_use_imm = out_use_imm; s_beq = out_is_beq; s_jump = out_is_jump;
    s_illegal = out_illegal; s_stall = stall_cnt;
    if (m_known) begin
      chk("out_valid", 64'(out_valid), 64'(ov));
      chk("in_ready", 64'(in_ready), 64'(ir));
      chk("alu_op", 64'(out_alu_op), 64'(inf.alu));
      chk("rd", 64'(out_rd), 64'(rd));
      chk("rs1", 64'(out_rs1), 64'(r1));
      chk("rs2", 64'(out_rs2), 64'(r2));
      chk("imm", 64'(out_imm), 64'(imm_of(m_ins)));
      chk("use_imm", 64'(out_use_imm), 64'(inf.use_imm));
      chk("is_beq", 64'(out_is_beq), 64'(inf.beq));
      chk("is_jump", 64'(out_is_jump), 64'(inf.jump));
      chk("illegal", 64'(out_illegal), 64'(inf.illegal));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    end
    @(posedge clk);
    if (rs) begin
      m_known = 1; m_hv = 0; m_ins = '0; m_busy = '0; m_stall = 0;
    end else begin
      if (m_hv && haz && !fl && m_stall < STALL_MAX) m_stall++;
      if (wbv) m_busy[wba] = 1'b0;
      if (fire && inf.wr && rd != 0) m_busy[rd] = 1'b1;
      if (acc) begin
        m_hv = 1; m_ins = ins;
      end else if (fire || fl) begin
        m_hv = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input bit ordy);
    cycle(0, 32'h0, ordy, 0, 0, 5'd0, 0);
  endtask

  task automatic wb(input logic [4:0] a);
    cycle(0, 32'h0, 1, 0, 1, a, 0);
  endtask

  task automatic do_reset();
    cycle(0, 32'h0, 0, 0, 0, 5'd0, 1);
    cycle(0, 32'h0, 0, 0, 0, 5'd0, 1);
  endtask

  function automatic logic [31:0] enc_r(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] r1, input logic [4:0] r2);
    return {op, rd, r1, r2, 13'd0};
  endfunction

  typedef struct {
    bit iv; logic [31:0] ins; bit ordy; bit wbv; logic [4:0] wba;
    bit e_ov; bit e_ir; int e_alu; int e_stall;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{iv:1, ins:32'h21844000, ordy:1, wbv:0, wba:5'd0, e_ov:0, e_ir:1, e_alu:0, e_stall:0};
    tbl[1] = '{iv:1, ins:32'hC28FFFFF, ordy:1, wbv:0, wba:5'd0, e_ov:1, e_ir:1, e_alu:2, e_stall:0};
    tbl[2] = '{iv:0, ins:32'h0,        ordy:1, wbv:0, wba:5'd0, e_ov:0, e_ir:0, e_alu:6, e_stall:0};
    tbl[3] = '{iv:0, ins:32'h0,        ordy:1, wbv:0, wba:5'd0, e_ov:0, e_ir:0, e_alu:6, e_stall:1};
    tbl[4] = '{iv:0, ins:32'h0,        ordy:1, wbv:1, wba:5'd3, e_ov:0, e_ir:0, e_alu:6, e_stall:2};
    tbl[5] = '{iv:0, ins:32'h0,        ordy:1, wbv:0, wba:5'd0, e_ov:1, e_ir:1, e_alu:6, e_stall:3};
    tbl[6] = '{iv:0, ins:32'h0,        ordy:1, wbv:0, wba:5'd0, e_ov:0, e_ir:1, e_alu:6, e_stall:3};

    // reset state
    do_reset();
    idle(1);
    chk("rst_out_valid", 64'(s_ov), 64'd0);
    chk("rst_in_ready", 64'(s_ir), 64'd1);
    chk("rst_alu_op", 64'(s_alu), 64'd0);
    chk("rst_stall", 64'(s_stall), 64'd0);

    // ADD r3,r1,r2 then dependent ADDI r5,r3,-1
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].iv, tbl[i].ins, tbl[i].ordy, 0, tbl[i].wbv, tbl[i].wba, 0);
      chk($sformatf("v%0d_ov", i), 64'(s_ov), 64'(tbl[i].e_ov));
      chk($sformatf("v%0d_ir", i), 64'(s_ir), 64'(tbl[i].e_ir));
      chk($sformatf("v%0d_alu", i), 64'(s_alu), 64'(tbl[i].e_alu));
      chk($sformatf("v%0d_stall", i), 64'(s_stall), 64'(tbl[i].e_stall));
      if (i == 1) chk("v1_rd", 64'(s_rd), 64'd3);
      if (i == 5) chk("v5_imm", 64'(s_imm), 64'hFFFF_FFFF);
    end

    // back-pressure: held SUB stays put, then back-to-back fires
    wb(5'd5);
    cycle(1, enc_r(4'd3, 5'd6, 5'd1, 5'd2), 0, 0, 0, 5'd0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, enc_r(4'd2, 5'd7, 5'd1, 5'd2), 0, 0, 0, 5'd0, 0);
      chk("bp_in_ready", 64'(s_ir), 64'd0);
      chk("bp_out_valid", 64'(s_ov), 64'd1);
      chk("bp_alu", 64'(s_alu), 64'd3);
      chk("bp_rd", 64'(s_rd), 64'd6);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1, enc_r(4'd2, 5'(7 + k), 5'd1, 5'd2), 1, 0, 0, 5'd0, 0);
      chk("b2b_out_valid", 64'(s_ov), 64'd1);
      chk("b2b_rd", 64'(s_rd), 64'(6 + k));
    end
    idle(1);
    chk("b2b_last_rd", 64'(s_rd), 64'd10);
    for (int r = 6; r <= 10; r++) wb(5'(r));

    // illegal, jump, beq stall, flush
    do_reset();
    cycle(1, enc_r(4'd6, 5'd11, 5'd0, 5'd0), 1, 0, 0, 5'd0, 0);
    cycle(1, enc_r(4'd2, 5'd12, 5'd11, 5'd11), 1, 0, 0, 5'd0, 0);
    chk("ill_flag", 64'(s_illegal), 64'd1);
    chk("ill_alu", 64'(s_alu), 64'd0);
    chk("ill_issue", 64'(s_ov), 64'd1);
    cycle(1, 32'h8ABCDEF0, 1, 0, 0, 5'd0, 0);
    chk("ill_no_busy", 64'(s_ov), 64'd1);
    cycle(1, enc_r(4'd2, 5'd3, 5'd0, 5'd0), 1, 0, 0, 5'd0, 0);
    chk("jump_flag", 64'(s_jump), 64'd1);
    chk("jump_issue", 64'(s_ov), 64'd1);
    cycle(1, enc_r(4'd9, 5'd0, 5'd3, 5'd0), 1, 0, 0, 5'd0, 0);
    idle(1);
    chk("beq_stall", 64'(s_ov), 64'd0);
    chk("beq_flag", 64'(s_beq), 64'd1);
    chk("beq_cnt0", 64'(s_stall), 64'd0);
    idle(1);
    chk("beq_cnt1", 64'(s_stall), 64'd1);
    cycle(1, enc_r(4'd2, 5'd13, 5'd3, 5'd0), 1, 1, 0, 5'd0, 0);
    chk("flush_ov", 64'(s_ov), 64'd0);
    chk("flush_ir", 64'(s_ir), 64'd0);
    chk("flush_cnt", 64'(s_stall), 64'd2);
    idle(1);
    chk("post_flush_ov", 64'(s_ov), 64'd0);
    chk("post_flush_ir", 64'(s_ir), 64'd1);
    chk("post_flush_cnt", 64'(s_stall), 64'd2);
    cycle(1, enc_r(4'd2, 5'd13, 5'd3, 5'd0), 1, 0, 0, 5'd0, 0);
    idle(1);
    chk("busy_kept", 64'(s_ov), 64'd0);
    wb(5'd3);
    chk("no_bypass", 64'(s_ov), 64'd0);
    idle(1);
    chk("after_wb_issue", 64'(s_ov), 64'd1);
    chk("after_wb_cnt", 64'(s_stall), 64'd4);

    // same-cycle set and clear of r4: set wins
    cycle(1, enc_r(4'd2, 5'd4, 5'd1, 5'd2), 1, 0, 0, 5'd0, 0);
    wb(5'd4);
    chk("setclr_fire", 64'(s_ov), 64'd1);
    cycle(1, enc_r(4'd2, 5'd14, 5'd4, 5'd0), 1, 0, 0, 5'd0, 0);
    idle(1);
    chk("setclr_busy", 64'(s_ov), 64'd0);
    wb(5'd4);
    idle(1);
    chk("setclr_release", 64'(s_ov), 64'd1);

    // stall counter saturation
    do_reset();
    cycle(1, enc_r(4'd2, 5'd3, 5'd0, 5'd0), 1, 0, 0, 5'd0, 0);
    cycle(1, enc_r(4'd2, 5'd5, 5'd3, 5'd0), 1, 0, 0, 5'd0, 0);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      chk("sat_cnt", 64'(s_stall), 64'((i < STALL_MAX) ? i : STALL_MAX));
    end
    wb(5'd3);
    idle(1);
    chk("sat_hold", 64'(s_stall), 64'(STALL_MAX));

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      bit iv, ordy, fl, wbv, rs;
      logic [4:0] wba;
      ins = $urandom;
      ins[27:23] = 5'($urandom_range(0, 3));
      ins[22:18] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) ins[17:13] = 5'($urandom_range(0, 3));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      wbv  = ($urandom_range(0, 2) == 0);
      wba  = 5'($urandom_range(0, 3));
      rs   = ($urandom_range(0, 199) == 0);
      cycle(iv, ins, ordy, fl, wbv, wba, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
